// File: rtl/mult_div_pkg.sv
// Shared types and sizing for the multicycle mult/div sequencer.
// The control unit imports this package to decode the busy and done states.
package mult_div_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = $clog2(MD_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } md_state_t;

endpackage

// File: rtl/md_sign_fix.sv
// Turns the unsigned magnitude result into signed Hi/Lo values.
// The multiply and divide paths both use this block.
module md_sign_fix
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [2*WIDTH-1:0] mag_i,
    input  logic               is_div_i,
    input  logic               sign_a_i,
    input  logic               sign_b_i,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        prod_fix = (sign_a_i ^ sign_b_i) ? -mag_i : mag_i;
        rem      = mag_i[2*WIDTH-1:WIDTH];
        quot     = mag_i[WIDTH-1:0];
        hi_o     = prod_fix[2*WIDTH-1:WIDTH];
        lo_o     = prod_fix[WIDTH-1:0];
        // The quotient truncates toward zero; the remainder follows the dividend sign.
        if (is_div_i) begin
            lo_o = (sign_a_i ^ sign_b_i) ? -quot : quot;
            hi_o = sign_a_i ? -rem : rem;
        end
    end

endmodule

// File: rtl/mult_div_seq.sv
// Multicycle MIPS mult/div sequencer: shift-add multiply, restoring divide,
// WIDTH iterations, then one sign-fix cycle that writes Hi/Lo.
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Magnitudes live in WIDTH-bit unsigned form, so |0x80..0| stays exact.
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier}, op = multiplicand.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, op_q & {WIDTH{acc_q[0]}}};

    // Divide: acc = {partial remainder, remaining dividend / quotient}, op = divisor.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, op_q};

    md_sign_fix #(
        .WIDTH(WIDTH)
    ) u_sign_fix (
        .mag_i   (acc_q),
        .is_div_i(is_div_q),
        .sign_a_i(sign_a_q),
        .sign_b_i(sign_b_q),
        .hi_o    (fix_hi),
        .lo_o    (fix_lo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        op_d     = op_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (start_mult) begin
                    state_d  = MULT;
                    acc_d    = {{WIDTH{1'b0}}, abs_b};
                    op_d     = abs_a;
                    is_div_d = 1'b0;
                    sign_a_d = a[WIDTH-1];
                    sign_b_d = b[WIDTH-1];
                    cnt_d    = '0;
                    dz_d     = 1'b0;
                end else if (start_div) begin
                    acc_d    = {{WIDTH{1'b0}}, abs_a};
                    op_d     = abs_b;
                    is_div_d = 1'b1;
                    sign_a_d = a[WIDTH-1];
                    sign_b_d = b[WIDTH-1];
                    cnt_d    = '0;
                    // A zero divisor skips straight to DONE and leaves Hi/Lo alone.
                    if (b == '0) begin
                        state_d = DONE;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = DIV;
                        dz_d    = 1'b0;
                    end
                end
            end
            MULT: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            DIV: begin
                if (!div_trial[WIDTH]) begin
                    acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                state_d = DONE;
            end
            DONE: begin
                dz_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign div_zero = (state_q == DONE) && dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
